// File: rtl/ha.sv
// Registered half adder/subtractor built from 2-input NANDs, with saturating op and carry counters.
// Optional macro HA_SUBTRACTOR_EN enables the subtract path selected by 'sub'.
module ha #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             in_valid,
    input  logic             sub,
    output logic             sum,
    output logic             carry,
    output logic             out_valid,
    output logic [CNT_W-1:0] op_cnt,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // NAND-only XOR and AND; the XOR also serves as the difference bit
    logic n1, xa, xb, s_x, c_add;
    logic res_sum, res_carry;

    assign n1    = ~(a & b);
    assign xa    = ~(a & n1);
    assign xb    = ~(b & n1);
    assign s_x   = ~(xa & xb);
    assign c_add = ~(n1 & n1);

`ifdef HA_SUBTRACTOR_EN
    logic na, nab, borrow;

    assign na        = ~(a & a);
    assign nab       = ~(na & b);
    assign borrow    = ~(nab & nab);
    assign res_sum   = s_x;
    assign res_carry = sub ? borrow : c_add;
`else
    logic unused_sub;

    assign unused_sub = sub;
    assign res_sum    = s_x;
    assign res_carry  = c_add;
`endif

    logic             sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
    logic [CNT_W-1:0] carry_cnt_q, carry_cnt_d;

    // Next-state: capture result and bump counters only on valid edges
    always_comb begin
        sum_d       = sum_q;
        carry_d     = carry_q;
        out_valid_d = 1'b0;
        op_cnt_d    = op_cnt_q;
        carry_cnt_d = carry_cnt_q;
        if (in_valid) begin
            sum_d       = res_sum;
            carry_d     = res_carry;
            out_valid_d = 1'b1;
            if (op_cnt_q != CNT_MAX) begin
                op_cnt_d = op_cnt_q + CNT_ONE;
            end
            if (res_carry && (carry_cnt_q != CNT_MAX)) begin
                carry_cnt_d = carry_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= 1'b0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            op_cnt_q    <= '0;
            carry_cnt_q <= '0;
        end else begin
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            op_cnt_q    <= op_cnt_d;
            carry_cnt_q <= carry_cnt_d;
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign out_valid = out_valid_q;
    assign op_cnt    = op_cnt_q;
    assign carry_cnt = carry_cnt_q;

endmodule

// File: tb/tb_ha.sv
// Directed bench for ha: default-width instance plus a CNT_W=2 instance for saturation.
module tb_ha;

    logic        clk;
    logic        rst_n;
    logic        a, b, in_valid, sub;
    logic        sum, carry, out_valid;
    logic [15:0] op_cnt, carry_cnt;
    logic        s_sum, s_carry, s_out_valid;
    logic [1:0]  s_op_cnt, s_carry_cnt;

    int checks = 0;
    int errors = 0;

    ha #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .sub(sub),
        .sum(sum), .carry(carry), .out_valid(out_valid),
        .op_cnt(op_cnt), .carry_cnt(carry_cnt)
    );

    ha #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .sub(sub),
        .sum(s_sum), .carry(s_carry), .out_valid(s_out_valid),
        .op_cnt(s_op_cnt), .carry_cnt(s_carry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the falling edge, sample just after the rising edge
    task automatic op(input logic ai, input logic bi, input logic si, input logic vi);
        @(negedge clk);
        a = ai; b = bi; sub = si; in_valid = vi;
        @(posedge clk);
        #1;
    endtask

    logic [1:0] add_vec [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [1:0] add_exp [4] = '{2'b00, 2'b10, 2'b10, 2'b01};
    logic [1:0] sub_exp [4] = '{2'b00, 2'b11, 2'b10, 2'b00};

    initial begin
        logic [1:0] v, e;
        rst_n = 1'b0; a = 1'b0; b = 1'b0; sub = 1'b0; in_valid = 1'b1;

        // Reset state, with in_valid high to confirm it is ignored
        repeat (2) @(posedge clk);
        #1;
        check("rst_sum", 32'(sum), 0);
        check("rst_carry", 32'(carry), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_op_cnt", 32'(op_cnt), 0);
        check("rst_carry_cnt", 32'(carry_cnt), 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // Add sweep
        for (int i = 0; i < 4; i++) begin
            v = add_vec[i];
            e = add_exp[i];
            op(v[1], v[0], 1'b0, 1'b1);
            check("add_sum", 32'(sum), 32'(e[1]));
            check("add_carry", 32'(carry), 32'(e[0]));
            check("add_out_valid", 32'(out_valid), 1);
            check("add_op_cnt", 32'(op_cnt), 32'(i + 1));
        end
        check("add_carry_cnt", 32'(carry_cnt), 1);
        check("sat_add_op_cnt", 32'(s_op_cnt), 3);
        check("sat_add_carry_cnt", 32'(s_carry_cnt), 1);

        // Hold on invalid cycle
        op(1'b0, 1'b1, 1'b0, 1'b0);
        check("hold_sum", 32'(sum), 0);
        check("hold_carry", 32'(carry), 1);
        check("hold_out_valid", 32'(out_valid), 0);
        check("hold_op_cnt", 32'(op_cnt), 4);
        check("hold_carry_cnt", 32'(carry_cnt), 1);

        // sub=1, a=0, b=1
        op(1'b0, 1'b1, 1'b1, 1'b1);
        check("sub1_sum", 32'(sum), 1);
`ifdef HA_SUBTRACTOR_EN
        check("sub1_borrow", 32'(carry), 1);
        check("sub1_carry_cnt", 32'(carry_cnt), 2);
`else
        check("sub1_carry", 32'(carry), 0);
        check("sub1_carry_cnt", 32'(carry_cnt), 1);
`endif
        check("sub1_op_cnt", 32'(op_cnt), 5);

`ifdef HA_SUBTRACTOR_EN
        // Subtract sweep, mode switching immediately from the prior add
        op(1'b1, 1'b1, 1'b0, 1'b1);
        check("mode_add_carry", 32'(carry), 1);
        for (int i = 0; i < 4; i++) begin
            v = add_vec[i];
            e = sub_exp[i];
            op(v[1], v[0], 1'b1, 1'b1);
            check("sub_diff", 32'(sum), 32'(e[1]));
            check("sub_borrow", 32'(carry), 32'(e[0]));
        end
        check("sub_carry_cnt", 32'(carry_cnt), 4);
`endif

        // Asynchronous reset mid-cycle, then in_valid ignored during reset
        op(1'b1, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_sum", 32'(sum), 0);
        check("async_carry", 32'(carry), 0);
        check("async_out_valid", 32'(out_valid), 0);
        check("async_op_cnt", 32'(op_cnt), 0);
        check("async_carry_cnt", 32'(carry_cnt), 0);
        a = 1'b1; b = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("inrst_op_cnt", 32'(op_cnt), 0);
        check("inrst_carry_cnt", 32'(carry_cnt), 0);
        check("inrst_out_valid", 32'(out_valid), 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        // First op after reset is normal
        op(1'b1, 1'b0, 1'b0, 1'b1);
        check("post_rst_sum", 32'(sum), 1);
        check("post_rst_carry", 32'(carry), 0);
        check("post_rst_op_cnt", 32'(op_cnt), 1);

        // Saturation: five 11 ops on top of one op already counted
        for (int i = 0; i < 5; i++) begin
            op(1'b1, 1'b1, 1'b0, 1'b1);
            check("sat_main_op_cnt", 32'(op_cnt), 32'(i + 2));
            check("sat_main_carry_cnt", 32'(carry_cnt), 32'(i + 1));
            check("sat_op_cnt", 32'(s_op_cnt), 32'((i + 2) > 3 ? 3 : (i + 2)));
            check("sat_carry_cnt", 32'(s_carry_cnt), 32'((i + 1) > 3 ? 3 : (i + 1)));
        end
        check("sat_final_op", 32'(s_op_cnt), 3);
        check("sat_final_carry", 32'(s_carry_cnt), 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
